// File: rtl/cla16_bist_checker_if.sv
// Operand/result bus between the BIST checker and the 16-bit adder under test.
// The checker drives operands as master; the adder answers as slave.
interface cla16_bist_checker_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;

  modport master (output a, output b, output cin, input sum, input cout);
  modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/cla16_bist_checker.sv
// Self-test engine for a 16-bit adder: drives two fixed vectors then LFSR vectors,
// waits SETTLE_CYCLES per vector, compares {cout,sum} with a+b+cin; start ignored while busy.
module cla16_bist_checker #(
  parameter int          NUM_VECTORS   = 256,
  parameter logic [31:0] SEED          = 32'hACE11234,
  parameter int          SETTLE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  cla16_bist_checker_if.master        adder,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [15:0]                 err_count,
  output logic [15:0]                 first_fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES);
  localparam logic [15:0] VEC0_A    = 16'hF0F0;
  localparam logic [15:0] VEC0_B    = 16'hCCCC;
  localparam logic [15:0] VEC1_A    = 16'hF0F0;
  localparam logic [15:0] VEC1_B    = 16'hF0CC;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_a, w_a;
  logic [15:0] r_b, w_b;
  logic        r_cin, w_cin;
  logic [15:0] r_idx, w_idx;
  logic [31:0] r_lfsr, w_lfsr;
  logic [15:0] r_settle, w_settle;
  logic [15:0] r_err, w_err;
  logic [15:0] r_ffi, w_ffi;
  logic        r_busy, w_busy;
  logic        r_done, w_done;

  logic [16:0] w_golden;
  logic        w_mismatch;
  logic [15:0] w_idx_inc;
  logic [31:0] w_lfsr_step;

  assign w_golden    = {1'b0, r_a} + {1'b0, r_b} + {16'd0, r_cin};
  assign w_mismatch  = (w_golden != {adder.cout, adder.sum});
  assign w_idx_inc   = r_idx + 16'd1;
  // Fibonacci LFSR, taps 32,22,2,1
  assign w_lfsr_step = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_idx    <= '0;
      r_lfsr   <= SEED_EFF;
      r_settle <= '0;
      r_err    <= '0;
      r_ffi    <= 16'hFFFF;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a;
      r_b      <= w_b;
      r_cin    <= w_cin;
      r_idx    <= w_idx;
      r_lfsr   <= w_lfsr;
      r_settle <= w_settle;
      r_err    <= w_err;
      r_ffi    <= w_ffi;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a         = r_a;
    w_b         = r_b;
    w_cin       = r_cin;
    w_idx       = r_idx;
    w_lfsr      = r_lfsr;
    w_settle    = r_settle;
    w_err       = r_err;
    w_ffi       = r_ffi;
    w_busy      = r_busy;
    w_done      = r_done;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_WAIT;
          w_a         = VEC0_A;
          w_b         = VEC0_B;
          w_cin       = 1'b0;
          w_idx       = '0;
          w_lfsr      = SEED_EFF;
          w_settle    = SETTLE_LD;
          w_err       = '0;
          w_ffi       = 16'hFFFF;
          w_busy      = 1'b1;
          w_done      = 1'b0;
        end
      end
      S_WAIT: begin
        w_settle = r_settle - 16'd1;
        if (r_settle == 16'd1) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_mismatch) begin
          if (r_err != 16'hFFFF) begin
            w_err = r_err + 16'd1;
          end
          if (r_ffi == 16'hFFFF) begin
            w_ffi = r_idx;
          end
        end
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
          w_busy      = 1'b0;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_idx       = w_idx_inc;
          w_settle    = SETTLE_LD;
          // second vector is fixed; the LFSR only advances from index 2 onward
          if (w_idx_inc == 16'd1) begin
            w_a   = VEC1_A;
            w_b   = VEC1_B;
            w_cin = 1'b1;
          end else begin
            w_lfsr = w_lfsr_step;
            w_a    = w_lfsr_step[31:16];
            w_b    = w_lfsr_step[15:0];
            w_cin  = w_lfsr_step[31] ^ w_lfsr_step[0];
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign adder.a        = r_a;
  assign adder.b        = r_b;
  assign adder.cin      = r_cin;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_done && (r_err == 16'd0);
  assign err_count      = r_err;
  assign first_fail_idx = r_ffi;

endmodule

// File: tb/tb_cla16_bist_checker.sv
// Randomised-adder-fault bench for cla16_bist_checker with a queue scoreboard.
module tb_cla16_bist_checker;
  localparam int          N    = 256;
  localparam int          S    = 1;
  localparam logic [31:0] SEED = 32'hACE11234;

  typedef struct packed { logic [15:0] a; logic [15:0] b; logic cin; } vec_t;
  typedef struct packed { logic [15:0] err; logic [15:0] ffi; logic pass; } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;
  int   fault = 0;   // 0 healthy, 1 sum[0] stuck-at-0, 2 cout stuck-at-1

  logic busy, done, pass, busy_s, done_s, pass_s;
  logic [15:0] err_count, first_fail_idx, err_count_s, first_fail_idx_s;

  int n_vec = 0;
  int n_bad = 0;
  vec_t exp_vq[$];
  res_t exp_rq[$];

  always #5 clk = ~clk;

  cla16_bist_checker_if bus();
  cla16_bist_checker_if bus_s();

  function automatic logic [16:0] faulty_add(logic [15:0] a, logic [15:0] b, logic c, int f);
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'd0, c};
    if (f == 1) r[0] = 1'b0;
    if (f == 2) r[16] = 1'b1;
    return r;
  endfunction

  assign {bus.cout, bus.sum}     = faulty_add(bus.a, bus.b, bus.cin, fault);
  assign {bus_s.cout, bus_s.sum} = faulty_add(bus_s.a, bus_s.b, bus_s.cin, 0);

  cla16_bist_checker #(.NUM_VECTORS(N), .SEED(SEED), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .adder(bus),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  cla16_bist_checker #(.NUM_VECTORS(2), .SEED(SEED), .SETTLE_CYCLES(3)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .adder(bus_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_count_s), .first_fail_idx(first_fail_idx_s)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the vector list and expected verdict of one whole run
  task automatic prep();
    logic [31:0] l;
    vec_t        v;
    int          errs;
    int          ffi;
    res_t        r;
    l    = SEED;
    errs = 0;
    ffi  = -1;
    for (int i = 0; i < N; i++) begin
      if (i == 0) v = '{16'hF0F0, 16'hCCCC, 1'b0};
      else if (i == 1) v = '{16'hF0F0, 16'hF0CC, 1'b1};
      else begin
        l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        v = '{l[31:16], l[15:0], l[31] ^ l[0]};
      end
      exp_vq.push_back(v);
      if (faulty_add(v.a, v.b, v.cin, fault) != ({1'b0, v.a} + {1'b0, v.b} + {16'd0, v.cin})) begin
        errs++;
        if (ffi < 0) ffi = i;
      end
    end
    r.err  = (errs > 65535) ? 16'hFFFF : 16'(errs);
    r.ffi  = (ffi < 0) ? 16'hFFFF : 16'(ffi);
    r.pass = (errs == 0);
    exp_rq.push_back(r);
  endtask

  task automatic launch();
    prep();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 2 * N * (S + 1) + 20) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("sb_drained", 32'(exp_vq.size() + exp_rq.size()), 32'd0);
  endtask

  // Monitor: checks each freshly loaded vector and the verdict at run end
  vec_t mv;
  res_t mr;
  int   cyc = 0;
  logic run = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 1'b0;
      end else if (busy) begin
        if (!run) begin
          run = 1'b1;
          cyc = 0;
        end
        if (cyc % (S + 1) == 0) begin
          if (exp_vq.size() == 0) begin
            chk("vec_unexpected", 32'(cyc), 32'hFFFF_FFFF);
          end else begin
            mv = exp_vq.pop_front();
            chk("vec_a", 32'(bus.a), 32'(mv.a));
            chk("vec_b", 32'(bus.b), 32'(mv.b));
            chk("vec_cin", 32'(bus.cin), 32'(mv.cin));
          end
        end
        cyc++;
      end else if (run) begin
        run = 1'b0;
        chk("run_cycles", 32'(cyc), 32'(N * (S + 1)));
        chk("done_at_end", 32'(done), 32'd1);
        if (exp_rq.size() == 0) begin
          chk("res_unexpected", 32'(err_count), 32'hFFFF_FFFF);
        end else begin
          mr = exp_rq.pop_front();
          chk("err_count", 32'(err_count), 32'(mr.err));
          chk("first_fail_idx", 32'(first_fail_idx), 32'(mr.ffi));
          chk("pass", 32'(pass), 32'(mr.pass));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ffi", 32'(first_fail_idx), 32'hFFFF);
    chk("rst_ab", 32'({bus.a, bus.b}), 32'd0);
    chk("rst_cin", 32'(bus.cin), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Minimum-length run with a longer settle window on the small instance
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    chk("s_v0", 32'({bus_s.a, bus_s.b}), 32'hF0F0_CCCC);
    chk("s_v0_cin", 32'(bus_s.cin), 32'd0);
    chk("s_v0_res", 32'({bus_s.cout, bus_s.sum}), 32'h1_BDBC);
    repeat (4) @(posedge clk);
    #1;
    chk("s_v1", 32'({bus_s.a, bus_s.b}), 32'hF0F0_F0CC);
    chk("s_v1_cin", 32'(bus_s.cin), 32'd1);
    chk("s_v1_res", 32'({bus_s.cout, bus_s.sum}), 32'h1_E1BD);
    repeat (3) @(posedge clk);
    #1;
    chk("s_done_early", 32'({busy_s, done_s}), 32'b10);
    @(posedge clk); #1;
    chk("s_done", 32'({busy_s, done_s, pass_s}), 32'b011);
    chk("s_err", 32'(err_count_s), 32'd0);
    chk("s_ffi", 32'(first_fail_idx_s), 32'hFFFF);
    chk("s_hold", 32'({bus_s.a, bus_s.b}), 32'hF0F0_F0CC);

    // Two back-to-back healthy runs must replay identical vectors
    launch(); wait_done();
    launch(); wait_done();

    // Start pulsed at index 5 is ignored
    launch();
    repeat (5 * (S + 1) - 1) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();

    // Reset mid-run at index 10
    launch();
    repeat (10 * (S + 1) - 1) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_vq.delete();
    exp_rq.delete();
    #1;
    chk("mid_rst_busy_done", 32'({busy, done, pass}), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    chk("mid_rst_ffi", 32'(first_fail_idx), 32'hFFFF);
    chk("mid_rst_ab", 32'({bus.a, bus.b, bus.cin}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    launch(); wait_done();

    // Faulty adders
    fault = 2;
    launch(); wait_done();
    fault = 1;
    launch(); wait_done();

    // Start held high in DONE restarts, then is ignored once busy
    fault = $urandom_range(0, 2);
    prep();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
